// File: rtl/fp_csa_pkg.sv
// Shared types and default sizes for the carry-save group accumulator.
package fp_csa_pkg;

  localparam int DEF_WIDTH = 29;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/csa_accum_csa32.sv
// One row of 3:2 compressors; cy is the carry vector already shifted into place.
module csa32
  import fp_csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] cy
);

  // The MSB majority would be shifted out, so it is never formed.
  logic [WIDTH-2:0] maj_lo;

  always_comb begin
    s      = a ^ b ^ c;
    maj_lo = (a[WIDTH-2:0] & b[WIDTH-2:0])
           | (a[WIDTH-2:0] & c[WIDTH-2:0])
           | (b[WIDTH-2:0] & c[WIDTH-2:0]);
    cy     = {maj_lo, 1'b0};
  end

endmodule

// File: rtl/csa_accum.sv
// Accumulates a group of terms in carry-save form and presents the redundant
// (sum, carry) pair to a downstream carry-select adder.
module csa_accum
  import fp_csa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_X_0,
  output logic [WIDTH-1:0] o_X_1,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat,
  output state_e           o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a producer holding valid keeps its payload stable until then.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] csa_s;
  logic [WIDTH-1:0] csa_cy;
  logic             accept;
  logic             start_new;

  csa32 #(.WIDTH(WIDTH)) u_csa32 (
    .a  (s_q),
    .b  (c_q),
    .c  (i_data),
    .s  (csa_s),
    .cy (csa_cy)
  );

  always_comb begin
    o_ready   = (state_q != HOLD) || i_ready;
    accept    = i_valid && o_ready;
    // In HOLD an accepted term implies i_ready, i.e. the result left this cycle.
    start_new = accept && (state_q != ACC);

    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    if (start_new) begin
      s_d     = i_data;
      c_d     = '0;
      cnt_d   = CNT_ONE;
      sat_d   = 1'b0;
      state_d = i_last ? HOLD : ACC;
    end else if (accept) begin
      s_d = csa_s;
      c_d = csa_cy;
      if (cnt_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      state_d = i_last ? HOLD : ACC;
    end else if ((state_q == HOLD) && i_ready) begin
      s_d     = '0;
      c_d     = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      state_d = IDLE;
    end

    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end

  assign o_X_0       = s_q;
  assign o_X_1       = c_q;
  assign o_cnt       = cnt_q;
  assign o_sat       = sat_q;
  assign o_valid     = valid_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_csa_accum.sv
// Directed bench for csa_accum: reset, group sums, wrap, backpressure,
// count saturation and reset in the middle of a group.
module tb_csa_accum;
  import fp_csa_pkg::*;

  localparam int WIDTH = 29;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             i_last;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_X_0;
  logic [WIDTH-1:0] o_X_1;
  logic [CNT_W-1:0] o_cnt;
  logic             o_sat;
  state_e           o_dbg_state;

  int n_checks;
  int n_fail;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] hold_x0;
  logic [WIDTH-1:0] hold_x1;

  csa_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_X_0       (o_X_0),
    .o_X_1       (o_X_1),
    .o_cnt       (o_cnt),
    .o_sat       (o_sat),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic last);
    i_valid = v;
    i_data  = d;
    i_last  = last;
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] exp_sum,
                              input logic [CNT_W-1:0] exp_cnt);
    sum_w = o_X_0 + o_X_1;
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_sum"},   32'(sum_w),   32'(exp_sum));
    check({tag, "_cnt"},   32'(o_cnt),   32'(exp_cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    i_ready  = 1'b1;
    drive(1'b0, '0, 1'b0);

    // reset held
    repeat (3) step();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_x0",    32'(o_X_0),   32'd0);
    check("rst_x1",    32'(o_X_1),   32'd0);
    check("rst_cnt",   32'(o_cnt),   32'd0);
    check("rst_sat",   32'(o_sat),   32'd0);
    rst = 1'b1;
    step();
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_state", 32'(o_dbg_state), 32'(IDLE));

    // three-term group: 5 + 7 + 9
    drive(1'b1, 29'd5, 1'b0);
    step();
    check("g3_state_acc", 32'(o_dbg_state), 32'(ACC));
    check("g3_valid_lo",  32'(o_valid), 32'd0);
    drive(1'b1, 29'd7, 1'b0);
    step();
    drive(1'b1, 29'd9, 1'b1);
    step();
    check_result("g3", 29'd21, 8'd3);
    check("g3_x0",  32'(o_X_0), 32'd1);
    check("g3_x1",  32'(o_X_1), 32'd20);
    check("g3_sat", 32'(o_sat), 32'd0);
    drive(1'b0, 29'h0ABCDEF, 1'b1);
    step();
    check("g3_drain_valid", 32'(o_valid), 32'd0);
    check("g3_drain_state", 32'(o_dbg_state), 32'(IDLE));
    check("g3_drain_cnt",   32'(o_cnt), 32'd0);
    check("g3_drain_x0",    32'(o_X_0), 32'd0);

    // single term at full scale
    drive(1'b1, 29'h1FFFFFFF, 1'b1);
    step();
    check_result("one", 29'h1FFFFFFF, 8'd1);
    check("one_x0", 32'(o_X_0), 32'h1FFFFFFF);
    check("one_x1", 32'(o_X_1), 32'd0);

    // wrap-around; first term starts a new group while the old one drains
    drive(1'b1, 29'h1FFFFFFF, 1'b0);
    step();
    check("wrap_valid_lo", 32'(o_valid), 32'd0);
    check("wrap_cnt_new",  32'(o_cnt),   32'd1);
    drive(1'b1, 29'd2, 1'b1);
    step();
    check_result("wrap", 29'd1, 8'd2);
    check("wrap_x0", 32'(o_X_0), 32'h1FFFFFFD);
    check("wrap_x1", 32'(o_X_1), 32'd4);

    // backpressure, with an offered term that must be ignored
    hold_x0 = 29'h1FFFFFFD;
    hold_x1 = 29'd4;
    i_ready = 1'b0;
    drive(1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) drive(1'b1, 29'd77, 1'b1);
      else        drive(1'b0, '0, 1'b0);
      step();
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_x0",    32'(o_X_0),   32'(hold_x0));
      check("bp_x1",    32'(o_X_1),   32'(hold_x1));
      check("bp_cnt",   32'(o_cnt),   32'd2);
    end
    i_ready = 1'b1;
    drive(1'b1, 29'd4, 1'b1);
    #1;
    check("bp_ready_release", 32'(o_ready), 32'd1);
    step();
    check_result("bp_next", 29'd4, 8'd1);
    check("bp_next_x1", 32'(o_X_1), 32'd0);
    drive(1'b0, '0, 1'b0);
    step();

    // count saturation: 256 terms of 1
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 29'd1, (k == 255));
      step();
      if (k == 254) check("sat_pre", 32'(o_sat), 32'd0);
    end
    check_result("sat", 29'd256, 8'd255);
    check("sat_flag", 32'(o_sat), 32'd1);
    drive(1'b1, 29'd6, 1'b1);
    step();
    check_result("sat_clear", 29'd6, 8'd1);
    check("sat_clear_flag", 32'(o_sat), 32'd0);
    drive(1'b0, '0, 1'b0);
    step();

    // reset in the middle of a group
    drive(1'b1, 29'd10, 1'b0);
    step();
    drive(1'b1, 29'd20, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_state", 32'(o_dbg_state), 32'(IDLE));
    check("mid_rst_cnt",   32'(o_cnt), 32'd0);
    check("mid_rst_x0",    32'(o_X_0), 32'd0);
    step();
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    drive(1'b1, 29'd3, 1'b1);
    step();
    check_result("mid_rst", 29'd3, 8'd1);
    check("mid_rst_x0_new", 32'(o_X_0), 32'd3);
    check("mid_rst_x1_new", 32'(o_X_1), 32'd0);
    drive(1'b0, '0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
